conv_encoder: RTL and testbench

Rate-1/2 convolutional encoder that sits directly upstream of `decoder_sys`, producing the 2-bit `encoded_bits` symbols that the Viterbi decoder consumes. The encoder accepts one information bit per handshake and emits one symbol per bit. Constraint length is selectable from 3 to 6 per frame. Each frame is terminated with K-1 zero tail bits, so the trellis ends in state 0.

---
 rtl/conv_encoder_pkg.sv | 44 ++++
 rtl/conv_encoder_if.sv | 26 ++
 rtl/conv_encoder_parity.sv | 25 ++
 rtl/conv_encoder.sv | 117 +++++++++++
 tb/tb_conv_encoder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_encoder_pkg.sv
// Shared constants, FSM state type and generator helpers for the rate-1/2
// convolutional encoder and its parity sub-block.
package conv_code_pkg;

  localparam int K_MIN      = 3;
  localparam int K_MAX      = 6;
  localparam int DATA_W_SYM = 2;

  localparam logic [K_MAX-1:0] G0_K3 = 6'o07;
  localparam logic [K_MAX-1:0] G1_K3 = 6'o05;
  localparam logic [K_MAX-1:0] G0_K4 = 6'o15;
  localparam logic [K_MAX-1:0] G1_K4 = 6'o17;
  localparam logic [K_MAX-1:0] G0_K5 = 6'o23;
  localparam logic [K_MAX-1:0] G1_K5 = 6'o35;
  localparam logic [K_MAX-1:0] G0_K6 = 6'o53;
  localparam logic [K_MAX-1:0] G1_K6 = 6'o75;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } state_t;

  function automatic logic [2:0] clamp_k(input logic [2:0] k);
    if (k < 3'(K_MIN)) return 3'(K_MIN);
    if (k > 3'(K_MAX)) return 3'(K_MAX);
    return k;
  endfunction

  // Generator left-aligned so the current-input tap always sits at bit K_MAX-1.
  function automatic logic [K_MAX-1:0] gen_taps(input logic [2:0] k, input logic sel_g1);
    logic [K_MAX-1:0] g;
    logic [2:0]       kc;
    kc = clamp_k(k);
    case (kc)
      3'd3:    g = sel_g1 ? G1_K3 : G0_K3;
      3'd4:    g = sel_g1 ? G1_K4 : G0_K4;
      3'd5:    g = sel_g1 ? G1_K5 : G0_K5;
      default: g = sel_g1 ? G1_K6 : G0_K6;
    endcase
    return g << (K_MAX - int'(kc));
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / symbol-out handshake bundle for the convolutional encoder.
interface conv_encoder_if;
  import conv_code_pkg::*;

  logic [2:0]            choose_constraint_length;
  logic                  in_bit;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_W_SYM-1:0] encoded_bits;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output choose_constraint_length, in_bit, in_valid, in_last, out_ready,
    input  in_ready, encoded_bits, out_valid, out_last, busy
  );

  modport slave (
    input  choose_constraint_length, in_bit, in_valid, in_last, out_ready,
    output in_ready, encoded_bits, out_valid, out_last, busy
  );

endinterface

// File: rtl/conv_encoder_parity.sv
// Combinational G0/G1 parity for one input bit against the stored history;
// only the newest k_sel-1 history bits contribute.
module conv_parity
  import conv_code_pkg::*;
(
  input  logic                  u,
  input  logic [K_MAX-2:0]      sr,
  input  logic [2:0]            k_sel,
  output logic [DATA_W_SYM-1:0] sym
);

  logic [K_MAX-1:0] taps_vec;

  // Input at the top, then history newest (sr[0]) to oldest.
  always_comb begin
    taps_vec[K_MAX-1] = u;
    for (int i = 0; i < K_MAX - 1; i++) begin
      taps_vec[K_MAX-2-i] = sr[i];
    end
  end

  assign sym = {^(taps_vec & gen_taps(k_sel, 1'b0)),
                ^(taps_vec & gen_taps(k_sel, 1'b1))};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder, K selectable 3..6 per frame, zero-tail
// terminated, with a single registered output symbol slot.
module conv_encoder
  import conv_code_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  conv_encoder_if.slave bus
);

  state_t                state_q, state_d;
  logic [K_MAX-2:0]      sr_q, sr_d;
  logic [2:0]            k_sel_q, k_sel_d;
  logic [2:0]            tail_cnt_q, tail_cnt_d;
  logic [DATA_W_SYM-1:0] sym_q, sym_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic                  slot_free;
  logic                  in_ready;
  logic                  accept_in;
  logic                  load_tail;
  logic                  u;
  logic [K_MAX-2:0]      sr_enc;
  logic [2:0]            k_enc;
  logic [DATA_W_SYM-1:0] parity;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = !rst && (state_q != TAIL) && slot_free;
  assign accept_in = in_ready && bus.in_valid;
  assign load_tail = (state_q == TAIL) && slot_free && (tail_cnt_q != 3'd0);

  // A frame's first bit encodes against cleared history and the freshly clamped K.
  assign sr_enc = (state_q == IDLE) ? '0 : sr_q;
  assign k_enc  = (state_q == IDLE) ? clamp_k(bus.choose_constraint_length) : k_sel_q;
  assign u      = (state_q == TAIL) ? 1'b0 : bus.in_bit;

  conv_parity u_parity (
    .u     (u),
    .sr    (sr_enc),
    .k_sel (k_enc),
    .sym   (parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      k_sel_q     <= 3'(K_MIN);
      tail_cnt_q  <= 3'd0;
      sym_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_sel_q     <= k_sel_d;
      tail_cnt_q  <= tail_cnt_d;
      sym_q       <= sym_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    k_sel_d    = k_sel_q;
    tail_cnt_d = tail_cnt_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (accept_in) begin
          k_sel_d = k_enc;
          sr_d    = {sr_enc[K_MAX-3:0], u};
          if (bus.in_last) begin
            state_d    = TAIL;
            tail_cnt_d = k_enc - 3'd1;
          end else begin
            state_d = RUN;
          end
        end
      end
      TAIL: begin
        if (load_tail) begin
          sr_d       = {sr_q[K_MAX-3:0], 1'b0};
          tail_cnt_d = tail_cnt_q - 3'd1;
        end else if (tail_cnt_q == 3'd0 && slot_free) begin
          // Final tail symbol has been taken downstream.
          state_d = IDLE;
          sr_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sym_d       = sym_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept_in || load_tail) begin
      sym_d       = parity;
      out_valid_d = 1'b1;
      out_last_d  = load_tail && (tail_cnt_q == 3'd1);
    end else if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.encoded_bits = sym_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: polynomial-convolution reference model,
// per-cycle output monitor, directed literal cases plus randomized frames.
module tb_conv_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ready_mode;

  logic       frame_bits[$];
  logic [2:0] frame_exp[$];
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  logic [2:0] lit_q[$];

  conv_encoder_if bus ();

  conv_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  // Reference: each output bit is the generator convolved with the input
  // stream extended by K-1 zeros; entries are {last, G0, G1}.
  task automatic buildModel(input logic [2:0] kreq);
    int   k;
    int   g0;
    int   g1;
    int   n;
    int   total;
    logic p0;
    logic p1;
    logic x;
    k = (kreq < 3'd3) ? 3 : (kreq > 3'd6) ? 6 : int'(kreq);
    case (k)
      3:       begin g0 = 'o7;  g1 = 'o5;  end
      4:       begin g0 = 'o15; g1 = 'o17; end
      5:       begin g0 = 'o23; g1 = 'o35; end
      default: begin g0 = 'o53; g1 = 'o75; end
    endcase
    frame_exp.delete();
    n     = frame_bits.size();
    total = n + k - 1;
    for (int t = 0; t < total; t++) begin
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < k; j++) begin
        x  = (t - j >= 0 && t - j < n) ? frame_bits[t-j] : 1'b0;
        p0 = p0 ^ (g0[k-1-j] & x);
        p1 = p1 ^ (g1[k-1-j] & x);
      end
      frame_exp.push_back({(t == total - 1), p0, p1});
    end
  endtask

  task automatic applyStimulus(input logic [2:0] kin, input int change_after,
                               input logic [2:0] k_new, input bit gaps);
    int   idx;
    int   guard;
    logic accepted;
    buildModel(kin);
    foreach (frame_exp[i]) exp_q.push_back(frame_exp[i]);
    got_q.delete();
    idx   = 0;
    guard = 0;
    while (idx < frame_bits.size()) begin
      bus.choose_constraint_length = (change_after >= 0 && idx >= change_after) ? k_new : kin;
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_bit   = frame_bits[idx];
      bus.in_last  = (idx == frame_bits.size() - 1);
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (accepted) idx++;
      guard++;
      if (guard > 3000) begin
        checkEq("input_timeout", 1, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    checkEq({name, "_drain"}, exp_q.size(), 0);
    checkEq({name, "_busy_after"}, bus.busy, 1'b0);
    checkEq({name, "_valid_after"}, bus.out_valid, 1'b0);
  endtask

  task automatic checkLiteral(input string name);
    checkEq({name, "_model_len"}, frame_exp.size(), lit_q.size());
    checkEq({name, "_dut_len"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size(); i++) begin
      if (i < frame_exp.size()) checkEq({name, "_model"}, frame_exp[i], lit_q[i]);
      if (i < got_q.size())     checkEq({name, "_dut"}, got_q[i], lit_q[i]);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: every accepted symbol is matched against the model queue.
  initial begin
    logic       prev_stall;
    logic [1:0] prev_sym;
    logic       prev_last;
    logic [2:0] e;
    prev_stall = 1'b0;
    prev_sym   = 2'b00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkEq("hold_sym", bus.encoded_bits, prev_sym);
          checkEq("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && !bus.out_ready) checkEq("stall_in_ready", bus.in_ready, 1'b0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_symbol: got %b, expected no symbol", {bus.out_last, bus.encoded_bits});
          end else begin
            e = exp_q.pop_front();
            checkEq("symbol", {bus.out_last, bus.encoded_bits}, e);
          end
          got_q.push_back({bus.out_last, bus.encoded_bits});
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_sym   = bus.encoded_bits;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    logic [2:0] kin;
    logic [2:0] knew;
    int         chg;

    checks     = 0;
    errors     = 0;
    ready_mode = 0;
    rst        = 1'b1;
    bus.choose_constraint_length = 3'd3;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_in_ready", bus.in_ready, 1'b0);
    checkEq("rst_out_valid", bus.out_valid, 1'b0);
    checkEq("rst_out_last", bus.out_last, 1'b0);
    checkEq("rst_encoded", bus.encoded_bits, 2'b00);
    checkEq("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    #1;
    checkEq("idle_in_ready", bus.in_ready, 1'b1);

    $display("[TB] K=3 frame 1,0,1,1");
    frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    lit_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    applyStimulus(3'd3, -1, 3'd3, 1'b0);
    checkOutput("k3_frame");
    checkLiteral("k3_frame");

    $display("[TB] K=6 impulse");
    frame_bits = '{1'b1};
    lit_q = '{3'b011, 3'b001, 3'b011, 3'b001, 3'b010, 3'b111};
    applyStimulus(3'd6, -1, 3'd6, 1'b0);
    checkOutput("k6_impulse");
    checkLiteral("k6_impulse");

    $display("[TB] clamp 7 -> K=6");
    applyStimulus(3'd7, -1, 3'd7, 1'b0);
    checkOutput("clamp7");
    checkLiteral("clamp7");

    $display("[TB] clamp 0 -> K=3");
    lit_q = '{3'b011, 3'b010, 3'b111};
    applyStimulus(3'd0, -1, 3'd0, 1'b0);
    checkOutput("clamp0");
    checkLiteral("clamp0");

    $display("[TB] backpressure");
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    lit_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    fork
      applyStimulus(3'd3, -1, 3'd3, 1'b0);
      begin
        int c;
        c = 0;
        while (!bus.out_valid && c < 50) begin
          @(posedge clk);
          #2;
          c++;
        end
        for (int i = 0; i < 5; i++) begin
          checkEq("bp_sym", bus.encoded_bits, 2'b11);
          checkEq("bp_in_ready", bus.in_ready, 1'b0);
          @(posedge clk);
          #2;
        end
        ready_mode = 0;
      end
    join
    checkOutput("bp");
    checkLiteral("bp");

    $display("[TB] mid-frame K change");
    frame_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(3'd3, 2, 3'd6, 1'b0);
    checkOutput("kchange");
    checkEq("kchange_len", got_q.size(), 7);
    if (got_q.size() == 7) checkEq("kchange_last", got_q[6][2], 1'b1);

    $display("[TB] reset during tail");
    frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    applyStimulus(3'd3, -1, 3'd3, 1'b0);
    @(posedge clk);
    #1;
    checkEq("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checkEq("mid_rst_valid", bus.out_valid, 1'b0);
    checkEq("mid_rst_last", bus.out_last, 1'b0);
    checkEq("mid_rst_busy", bus.busy, 1'b0);
    checkEq("mid_rst_in_ready", bus.in_ready, 1'b1);
    lit_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    applyStimulus(3'd3, -1, 3'd3, 1'b0);
    checkOutput("post_rst");
    checkLiteral("post_rst");

    $display("[TB] random frames");
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      frame_bits.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
      kin  = 3'($urandom_range(0, 7));
      knew = 3'($urandom_range(0, 7));
      chg  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, n) : -1;
      applyStimulus(kin, chg, knew, 1'b1);
      checkOutput("rand");
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
